// File: rtl/nonce_search_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nonce_search_ctrl
// Brief    : Drives the hash core across a nonce range, tracks the best digest
//            and hands one result record per job to the transmit path.
//            Optional core watchdog enabled by defining CORE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nonce_search_ctrl #(
  parameter int NONCE_W        = 32,
  parameter int DIGEST_W       = 256,
  parameter int CMP_W          = 32,
  parameter int COUNT_W        = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                job_valid_i,
  output logic                job_ready_o,
  input  logic [NONCE_W-1:0]  job_nonce_i,
  input  logic [CMP_W-1:0]    job_target_i,
  input  logic                second_tick_i,
  output logic                core_start_o,
  output logic [NONCE_W-1:0]  core_nonce_o,
  input  logic                core_done_i,
  input  logic [DIGEST_W-1:0] core_digest_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic                res_found_o,
  output logic [NONCE_W-1:0]  res_nonce_o,
  output logic [CMP_W-1:0]    res_digest_hi_o,
  output logic [COUNT_W-1:0]  res_count_o,
  output logic                res_error_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t               r_state, w_next_state;
  logic [CMP_W-1:0]     r_target, r_best, w_hi, w_best_hi;
  logic [NONCE_W-1:0]   r_start_nonce, r_nonce, r_best_nonce, w_best_nonce, w_nonce_inc;
  logic [COUNT_W-1:0]   r_count, w_count_inc;
  logic                 r_stop, r_res_found;
  logic [NONCE_W-1:0]   r_res_nonce;
  logic [CMP_W-1:0]     r_res_hi;
  logic [COUNT_W-1:0]   r_res_count;
  logic                 w_hit, w_better, w_terminal, w_timeout;

  assign w_hi         = core_digest_i[DIGEST_W-1 -: CMP_W];
  assign w_hit        = w_hi < r_target;
  assign w_better     = w_hi < r_best;
  assign w_best_hi    = w_better ? w_hi : r_best;
  assign w_best_nonce = w_better ? r_nonce : r_best_nonce;
  assign w_count_inc  = (&r_count) ? r_count : r_count + 1'b1;
  assign w_nonce_inc  = r_nonce + 1'b1;
  // Wrapping back onto the start nonce means the whole space has been tried.
  assign w_terminal   = w_hit | r_stop | second_tick_i | (w_nonce_inc == r_start_nonce);

  generate
    if (DIGEST_W > CMP_W) begin : g_digest_lsb
      logic w_unused_digest_lsb;
      assign w_unused_digest_lsb = ^core_digest_i[DIGEST_W-CMP_W-1:0];
    end
  endgenerate

`ifdef CORE_TIMEOUT_EN
  localparam int c_wd_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_wd_w-1:0] r_wd;
  logic              r_res_error;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)                  r_wd <= '0;
    else if (r_state == S_ISSUE) r_wd <= '0;
    else if (r_state == S_WAIT)  r_wd <= r_wd + 1'b1;
  end

  assign w_timeout = (r_state == S_WAIT) & ~core_done_i &
                     (r_wd == c_wd_w'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)                                    r_res_error <= 1'b0;
    else if (w_timeout)                           r_res_error <= 1'b1;
    else if ((r_state == S_REPORT) && res_ready_i) r_res_error <= 1'b0;
  end

  assign res_error_o = r_res_error;
`else
  localparam int c_timeout_unused = TIMEOUT_CYCLES;

  assign w_timeout   = 1'b0;
  assign res_error_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (job_valid_i) w_next_state = S_ISSUE;
      S_ISSUE:  w_next_state = S_WAIT;
      S_WAIT: begin
        if (core_done_i)    w_next_state = w_terminal ? S_REPORT : S_ISSUE;
        else if (w_timeout) w_next_state = S_REPORT;
      end
      S_REPORT: if (res_ready_i) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_target      <= '0;
      r_start_nonce <= '0;
      r_nonce       <= '0;
      r_count       <= '0;
      r_best        <= '1;
      r_best_nonce  <= '0;
      r_stop        <= 1'b0;
      r_res_found   <= 1'b0;
      r_res_nonce   <= '0;
      r_res_hi      <= '0;
      r_res_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (job_valid_i) begin
            r_target      <= job_target_i;
            r_start_nonce <= job_nonce_i;
            r_nonce       <= job_nonce_i;
            r_count       <= '0;
            r_best        <= '1;
            r_best_nonce  <= job_nonce_i;
            r_stop        <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (second_tick_i) r_stop <= 1'b1;
        end
        S_WAIT: begin
          if (second_tick_i) r_stop <= 1'b1;
          if (core_done_i) begin
            r_count      <= w_count_inc;
            r_best       <= w_best_hi;
            r_best_nonce <= w_best_nonce;
            if (!w_terminal) begin
              r_nonce <= w_nonce_inc;
            end else begin
              // A target hit reports the hitting nonce, otherwise the best one.
              r_res_found <= w_hit;
              r_res_nonce <= w_hit ? r_nonce : w_best_nonce;
              r_res_hi    <= w_hit ? w_hi : w_best_hi;
              r_res_count <= w_count_inc;
            end
          end else if (w_timeout) begin
            r_res_found <= 1'b0;
            r_res_nonce <= r_best_nonce;
            r_res_hi    <= r_best;
            r_res_count <= r_count;
          end
        end
        S_REPORT: begin
          if (res_ready_i) begin
            r_res_found <= 1'b0;
            r_res_nonce <= '0;
            r_res_hi    <= '0;
            r_res_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign job_ready_o     = (r_state == S_IDLE);
  assign core_start_o    = (r_state == S_ISSUE);
  assign core_nonce_o    = r_nonce;
  assign res_valid_o     = (r_state == S_REPORT);
  assign res_found_o     = r_res_found;
  assign res_nonce_o     = r_res_nonce;
  assign res_digest_hi_o = r_res_hi;
  assign res_count_o     = r_res_count;

endmodule
`default_nettype wire

// File: tb/tb_nonce_search_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nonce_search_ctrl
// Brief    : Randomized bench for nonce_search_ctrl with a behavioural core
//            and a sequence-level result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonce_search_ctrl;
  localparam int NW   = 6;
  localparam int DW   = 64;
  localparam int CW   = 32;
  localparam int KW   = 5;
  localparam int TO   = 16;
  localparam int NN   = 1 << NW;
  localparam int KMAX = (1 << KW) - 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready_o;
  logic [NW-1:0] job_nonce = '0;
  logic [CW-1:0] job_target = '0;
  logic          tick = 1'b0;
  logic          core_start_o;
  logic [NW-1:0] core_nonce_o;
  logic          core_done = 1'b0;
  logic [DW-1:0] core_digest = '0;
  logic          res_valid_o;
  logic          res_ready = 1'b0;
  logic          res_found_o;
  logic [NW-1:0] res_nonce_o;
  logic [CW-1:0] res_digest_hi_o;
  logic [KW-1:0] res_count_o;
  logic          res_error_o;

  always #5 clk = ~clk;

  nonce_search_ctrl #(
    .NONCE_W(NW), .DIGEST_W(DW), .CMP_W(CW), .COUNT_W(KW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_i(rst_i),
    .job_valid_i(job_valid), .job_ready_o(job_ready_o),
    .job_nonce_i(job_nonce), .job_target_i(job_target),
    .second_tick_i(tick),
    .core_start_o(core_start_o), .core_nonce_o(core_nonce_o),
    .core_done_i(core_done), .core_digest_i(core_digest),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready),
    .res_found_o(res_found_o), .res_nonce_o(res_nonce_o),
    .res_digest_hi_o(res_digest_hi_o), .res_count_o(res_count_o),
    .res_error_o(res_error_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] tbl [NN];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Walks the nonce sequence from start and applies the stop rules in order.
  task automatic model(input int start, input logic [31:0] target, input int tick_at,
                       output bit found, output int rn, output logic [31:0] rhi,
                       output int rcnt, output int hashes);
    logic [31:0] best;
    int bn, n;
    best = '1; bn = start; found = 0; rn = start; rhi = '1; hashes = 0;
    for (int i = 0; i < NN; i++) begin
      n = (start + i) % NN;
      hashes = i + 1;
      if (tbl[n] < best) begin best = tbl[n]; bn = n; end
      if (tbl[n] < target) begin found = 1; rn = n; rhi = tbl[n]; break; end
      if (hashes == tick_at || hashes == NN) begin rn = bn; rhi = best; break; end
    end
    rcnt = (hashes > KMAX) ? KMAX : hashes;
  endtask

  task automatic resync();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  // tick_mode: 0 = mid-WAIT, 1 = with done, 2 = during ISSUE
  task automatic run_job(input int start, input logic [31:0] target, input int tick_at,
                         input int tick_mode, input int fixed_lat, input int ready_delay);
    bit e_found;
    int e_nonce, e_cnt, e_hashes, n, lat;
    logic [31:0] e_hi;
    model(start, target, tick_at, e_found, e_nonce, e_hi, e_cnt, e_hashes);
    @(negedge clk);
    job_valid = 1'b1; job_nonce = NW'(start); job_target = target;
    check("job_ready", job_ready_o, 1);
    @(negedge clk);
    job_valid = 1'b0;
    for (int h = 1; h <= e_hashes; h++) begin
      n = (start + h - 1) % NN;
      check("core_start", core_start_o, 1);
      check("core_nonce", core_nonce_o, n);
      check("res_valid_busy", res_valid_o, 0);
      tick = (h == tick_at) && (tick_mode == 2);
      lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 5);
      if (h == tick_at && tick_mode == 0 && lat < 2) lat = 2;
      for (int w = 1; w <= lat; w++) begin
        @(negedge clk);
        tick = (h == tick_at) && ((tick_mode == 0 && w == 1) || (tick_mode == 1 && w == lat));
        check("nonce_hold", core_nonce_o, n);
        if (w == lat) begin
          core_done = 1'b1;
          core_digest = {tbl[n], $urandom};
        end
      end
      @(negedge clk);
      core_done = 1'b0; tick = 1'b0;
    end
    check("no_extra_start", core_start_o, 0);
    check("res_valid", res_valid_o, 1);
    check("res_found", res_found_o, e_found);
    check("res_nonce", res_nonce_o, e_nonce);
    check("res_digest_hi", res_digest_hi_o, e_hi);
    check("res_count", res_count_o, e_cnt);
    check("res_error", res_error_o, 0);
    for (int d = 0; d < ready_delay; d++) begin
      tick = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_valid", res_valid_o, 1);
      check("hold_nonce", res_nonce_o, e_nonce);
      check("hold_hi", res_digest_hi_o, e_hi);
      check("hold_count", res_count_o, e_cnt);
    end
    tick = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_hs_ready", job_ready_o, 1);
    check("post_hs_valid", res_valid_o, 0);
    if (job_ready_o !== 1'b1) resync();
  endtask

  initial begin
    int s, k, mode, tsel, tat, tmode;
    logic [31:0] v, tgt;

    @(negedge clk);
    check("rst_job_ready", job_ready_o, 1);
    check("rst_core_start", core_start_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_res_found", res_found_o, 0);
    check("rst_res_nonce", res_nonce_o, 0);
    check("rst_res_hi", res_digest_hi_o, 0);
    check("rst_res_count", res_count_o, 0);
    check("rst_res_error", res_error_o, 0);
    rst_i = 1'b0;

    // Single hash meets a permissive target
    for (int i = 0; i < NN; i++) tbl[i] = 32'hF000_0000;
    tbl[6'h10] = 32'h5;
    run_job(6'h10, 32'hFFFF_FFFF, 0, 0, 8, 0);

    // Descending digests reach the target on the third nonce
    tbl[0] = 32'h1000; tbl[1] = 32'h800; tbl[2] = 32'h0;
    run_job(0, 32'h100, 0, 0, 0, 1);

    // Tick mid-WAIT of hash 6 with heavy ties
    for (int i = 0; i < NN; i++) tbl[i] = $urandom_range(1, 7) << 28;
    run_job(3, 32'h0, 6, 0, 0, 2);

    // Tick together with a winning done: target has priority
    for (int i = 0; i < NN; i++) tbl[i] = 32'hA000_0000;
    tbl[5] = 32'h9000_0000; tbl[6] = 32'h8000_0000; tbl[7] = 32'h10;
    run_job(5, 32'h100, 3, 1, 0, 0);

    // Ticks while idle must not leak into the next job
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); tick = 1'b1;
    end
    @(negedge clk); tick = 1'b0;
    tbl[24] = 32'h3;
    run_job(20, 32'h100, 0, 0, 0, 0);

    // Full space exhaustion with wrap; count saturates; long backpressure
    for (int i = 0; i < NN; i++) begin
      v = $urandom;
      tbl[i] = (v == 32'hFFFF_FFFF) ? 32'h0 : v;
    end
    run_job(6'h3E, 32'h0, 0, 0, 0, 10);

    // Reset during WAIT, then a stale done
    tbl[9] = 32'h1;
    @(negedge clk);
    job_valid = 1'b1; job_nonce = 6'd9; job_target = 32'hFFFF_FFFF;
    @(negedge clk); job_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("async_rst_ready", job_ready_o, 1);
    check("async_rst_valid", res_valid_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    core_done = 1'b1; core_digest = '0;
    @(negedge clk);
    core_done = 1'b0;
    check("late_done_ready", job_ready_o, 1);
    check("late_done_valid", res_valid_o, 0);
    check("late_done_start", core_start_o, 0);

`ifdef CORE_TIMEOUT_EN
    tbl[9] = 32'h1234;
    @(negedge clk);
    job_valid = 1'b1; job_nonce = 6'd9; job_target = 32'h0;
    @(negedge clk); job_valid = 1'b0;
    check("to_start1", core_start_o, 1);
    @(negedge clk);
    @(negedge clk); core_done = 1'b1; core_digest = {tbl[9], 32'h0};
    @(negedge clk); core_done = 1'b0;
    check("to_start2", core_start_o, 1);
    k = 0;
    while (res_valid_o !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("to_cycles", k, 17);
    check("to_error", res_error_o, 1);
    check("to_found", res_found_o, 0);
    check("to_nonce", res_nonce_o, 9);
    check("to_hi", res_digest_hi_o, 32'h1234);
    check("to_count", res_count_o, 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("to_error_clr", res_error_o, 0);
    if (job_ready_o !== 1'b1) resync();
`endif

    for (int j = 0; j < 20; j++) begin
      mode = $urandom_range(0, 1);
      for (int i = 0; i < NN; i++) begin
        v = $urandom;
        if (mode == 1) v = $urandom_range(1, 7) << 28;
        tbl[i] = (v == 32'hFFFF_FFFF) ? 32'h0 : v;
      end
      tsel = $urandom_range(0, 2);
      tgt = (tsel == 0) ? 32'h0 : (tsel == 1) ? $urandom_range(0, 32'h0400_0000) : $urandom;
      tat = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
      tmode = $urandom_range(0, 2);
      s = $urandom_range(0, NN - 1);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
      end
      run_job(s, tgt, tat, tmode, 0, $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
Sequences the multi-cycle hash core during the hashing window of the accelerator. Accepts a job (start nonce, target), then repeatedly issues nonces to the core and checks each digest against the target. Tracks the best digest seen and stops on one of three events: target met, time-slot tick, or nonce space exhausted. Hands one result record to the transmit path over a valid/ready handshake.

Parameters:
NONCE_W, 32, nonce width; also the width of core_nonce_o and res_nonce_o
DIGEST_W, 256, width of the core digest
CMP_W, 32, number of digest MSBs compared against the target (CMP_W <= DIGEST_W)
COUNT_W, 32, width of the attempted-hash counter
TIMEOUT_CYCLES, 1024, core watchdog limit; used only with CORE_TIMEOUT_EN

Ports:
clk  in  1  clock
rst_i  in  1  asynchronous, active-high reset
job_valid_i  in  1  job offered
job_ready_o  out  1  controller idle, can accept a job
job_nonce_i  in  NONCE_W  first nonce to try
job_target_i  in  CMP_W  success when digest MSBs < target (unsigned)
second_tick_i  in  1  one-cycle time-slot pulse; requests stop
core_start_o  out  1  one-cycle start pulse to the hash core
core_nonce_o  out  NONCE_W  nonce for the core; stable from start until done
core_done_i  in  1  one-cycle pulse; core_digest_i valid in the same cycle
core_digest_i  in  DIGEST_W  digest from the core
res_valid_o  out  1  result record valid
res_ready_i  in  1  transmit path accepts the record
res_found_o  out  1  target met
res_nonce_o  out  NONCE_W  winning nonce if found, otherwise best nonce
res_digest_hi_o  out  CMP_W  digest MSBs that belong to res_nonce_o
res_count_o  out  COUNT_W  digests checked; saturates at all-ones
res_error_o  out  1  core timeout; tied 0 when CORE_TIMEOUT_EN is undefined

Behaviour:
- States: IDLE, ISSUE, WAIT, REPORT.
- Reset: state IDLE. All outputs 0 except job_ready_o=1. Internal best value set to all-ones; stop flag cleared.
- A reset asserted in any state returns to IDLE immediately. An in-flight core_done_i that arrives after reset is ignored.
- IDLE:
  - job_ready_o=1.
  - On job_valid_i & job_ready_o: latch target and nonce, count=0, best=all-ones, stop=0, go to ISSUE.
- ISSUE:
  - core_start_o=1 for exactly this cycle; go to WAIT.
  - core_start_o rises the cycle after job acceptance, and the cycle after a non-terminal core_done_i.
- WAIT:
  - Hold core_nonce_o stable.
  - On core_done_i:
    - h = core_digest_i[DIGEST_W-1 -: CMP_W]; increment count (saturating).
    - If h < best: best = h, best_nonce = nonce. Ties keep the earlier nonce.
    - Exit priority, highest first:
      1. h < target: found=1, report this nonce and h.
      2. stop flag set, or second_tick_i in the same cycle: found=0.
      3. nonce+1 (mod 2^NONCE_W) equals the start nonce (space exhausted): found=0.
      4. Otherwise nonce += 1 (wraps), go to ISSUE.
    - Cases 1–3 go to REPORT.
- second_tick_i:
  - Sets the stop flag in ISSUE or WAIT.
  - Ignored in IDLE and REPORT.
  - Never aborts the core; the in-flight hash always completes and is checked.
- REPORT:
  - res_valid_o=1 with res_* registered at entry.
  - Hold res_valid_o and all res_* stable until res_valid_o & res_ready_i, then go to IDLE.
  - res_valid_o rises the cycle after the terminal core_done_i.
- core_done_i outside WAIT is ignored.

Optional Feature:
CORE_TIMEOUT_EN
- Defined:
  - A watchdog counts WAIT cycles.
  - If TIMEOUT_CYCLES elapse without core_done_i, go to REPORT with res_error_o=1, res_found_o=0, and best-so-far in res_nonce_o/res_digest_hi_o.
  - count is not incremented for the timed-out hash.
  - res_error_o clears on handshake.
- Undefined: no watchdog; WAIT lasts until core_done_i; res_error_o=0 constant.

Test Plan:
1. Job nonce=0x10, target=0xFFFFFFFF; core returns digest MSBs 0x00000005 after 8 cycles -> single core_start_o with core_nonce_o=0x10; res_valid_o the cycle after done; found=1, nonce=0x10, digest_hi=0x5, count=1.
2. target=0x100; core model digest_hi = 0x1000 - nonce*0x800, start nonce 0 -> nonces 0,1,2 issued; found=1 at nonce 2 (hi=0x0); count=3; one-cycle ISSUE gap between done and next start.
3. target=0, tick pulsed mid-WAIT of the 6th hash -> 6th hash completes, no 7th start; found=0, count=6, res_nonce_o is the nonce with the minimum hi (earliest on tie).
4. Tick in the same cycle as a done whose hi < target -> found=1 (target wins). Tick in IDLE -> next job runs normally.
5. NONCE_W=4, start=0xE, target=0, no tick -> 16 starts (E,F,0..D), then REPORT with found=0, count=16; res_ready_i held low 10 cycles -> res_* stable throughout.
6. Reset asserted in WAIT -> next cycle IDLE, job_ready_o=1, res_valid_o=0; late core_done_i ignored. With CORE_TIMEOUT_EN and TIMEOUT_CYCLES=16, core never completes -> res_error_o=1 after 16 WAIT cycles.
